// File: rtl/mandel_sched_pkg.sv
// Shared types and widths for the Mandelbrot pixel scheduler slice.
package mandel_sched_pkg;

  localparam int COORD_W   = 16;
  localparam int DEPTH_W   = 8;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;
  localparam int FRAC      = 8;
  localparam int DEF_H_RES = 640;
  localparam int DEF_V_RES = 480;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } sched_state_e;

endpackage

// File: rtl/mandel_pixel_scheduler_if.sv
// Raster-ordered pixel stream from the scheduler toward colour mapping / framebuffer.
interface mandel_pixel_scheduler_if;
  import mandel_sched_pkg::*;

  logic               pix_valid;
  logic               pix_ready;
  logic [X_W-1:0]     pix_x;
  logic [Y_W-1:0]     pix_y;
  logic [DEPTH_W-1:0] pix_depth;
  logic               pix_sof;
  logic               pix_eol;

  modport master (
    output pix_valid, pix_x, pix_y, pix_depth, pix_sof, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  pix_valid, pix_x, pix_y, pix_depth, pix_sof, pix_eol,
    output pix_ready
  );
endinterface

// File: rtl/mandel_pixel_scheduler_coord_gen.sv
// Raster walker: x/y counters plus incremental complex coordinate of the current pixel.
module mandel_coord_gen
  import mandel_sched_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES
) (
  input  logic               sysclk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic               advance_i,
  input  logic [COORD_W-1:0] re_origin_i,
  input  logic [COORD_W-1:0] im_origin_i,
  input  logic [COORD_W-1:0] step_i,
  output logic [X_W-1:0]     x_o,
  output logic [Y_W-1:0]     y_o,
  output logic [COORD_W-1:0] re_o,
  output logic [COORD_W-1:0] im_o,
  output logic               last_o
);

  logic [X_W-1:0]     xQ, xD;
  logic [Y_W-1:0]     yQ, yD;
  logic [COORD_W-1:0] reQ, reD, imQ, imD, reOriginQ, reOriginD, stepQ, stepD;
  logic               lineEnd;

  assign lineEnd = (xQ == X_W'(H_RES - 1));

  // Additions wrap in 16-bit two's complement; the real axis reloads at each line start.
  always_comb begin
    xD        = xQ;
    yD        = yQ;
    reD       = reQ;
    imD       = imQ;
    reOriginD = reOriginQ;
    stepD     = stepQ;
    if (load_i) begin
      xD        = '0;
      yD        = '0;
      reD       = re_origin_i;
      imD       = im_origin_i;
      reOriginD = re_origin_i;
      stepD     = step_i;
    end else if (advance_i) begin
      if (lineEnd) begin
        xD  = '0;
        yD  = (yQ == Y_W'(V_RES - 1)) ? '0 : yQ + 1'b1;
        reD = reOriginQ;
        imD = imQ - stepQ;
      end else begin
        xD  = xQ + 1'b1;
        reD = reQ + stepQ;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      xQ        <= '0;
      yQ        <= '0;
      reQ       <= '0;
      imQ       <= '0;
      reOriginQ <= '0;
      stepQ     <= '0;
    end else begin
      xQ        <= xD;
      yQ        <= yD;
      reQ       <= reD;
      imQ       <= imD;
      reOriginQ <= reOriginD;
      stepQ     <= stepD;
    end
  end

  assign x_o    = xQ;
  assign y_o    = yQ;
  assign re_o   = reQ;
  assign im_o   = imQ;
  assign last_o = lineEnd && (yQ == Y_W'(V_RES - 1));

endmodule

// File: rtl/mandel_pixel_scheduler.sv
// Frame scheduler: round-robin dispatch to depth engines, in-order retire onto a pixel stream.
// Define SCHED_PERF_EN to add the perf_cycles / perf_stalls counters.
module mandel_pixel_scheduler
  import mandel_sched_pkg::*;
#(
  parameter int NUM_ENGINES = 4,
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES
) (
  input  logic                           sysclk,
  input  logic                           reset_n,
  input  logic                           frame_start,
  input  logic [COORD_W-1:0]             re_origin,
  input  logic [COORD_W-1:0]             im_origin,
  input  logic [COORD_W-1:0]             step,
  input  logic [DEPTH_W-1:0]             max_iter_in,
  output logic                           busy,
  output logic                           frame_done,
  output logic [NUM_ENGINES-1:0]         eng_start,
  output logic [NUM_ENGINES*COORD_W-1:0] eng_re_c,
  output logic [NUM_ENGINES*COORD_W-1:0] eng_im_c,
  output logic [DEPTH_W-1:0]             eng_max_iter,
  input  logic [NUM_ENGINES-1:0]         eng_done,
  input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
  mandel_pixel_scheduler_if.master       pix
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]                    perf_cycles,
  output logic [31:0]                    perf_stalls
`endif
);

  localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  sched_state_e         stateQ, stateD;
  logic [PTR_W-1:0]     issuePtrQ, issuePtrD, retirePtrQ, retirePtrD;
  logic [NUM_ENGINES-1:0] slotBusyQ, slotBusyD, resValidQ, resValidD, doneQ, captureEn;
  logic [COORD_W-1:0]   slotReQ    [NUM_ENGINES];
  logic [COORD_W-1:0]   slotImQ    [NUM_ENGINES];
  logic [X_W-1:0]       slotXQ     [NUM_ENGINES];
  logic [Y_W-1:0]       slotYQ     [NUM_ENGINES];
  logic [DEPTH_W-1:0]   slotDepthQ [NUM_ENGINES];
  logic [DEPTH_W-1:0]   maxIterQ;

  logic                 frameAccept, runEn, dispatch, retire;
  logic [X_W-1:0]       coordX;
  logic [Y_W-1:0]       coordY;
  logic [COORD_W-1:0]   coordRe, coordIm;
  logic                 coordLast;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_ENGINES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign frameAccept = (stateQ == IDLE) && frame_start;
  assign dispatch    = runEn && !slotBusyQ[issuePtrQ];
  assign retire      = pix.pix_valid && pix.pix_ready;
  // Only a fresh done edge on an outstanding slot counts; a level left over from the previous pixel is ignored.
  assign captureEn   = eng_done & ~doneQ & slotBusyQ & ~resValidQ;

  mandel_coord_gen #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_coord_gen (
    .sysclk      (sysclk),
    .reset_n     (reset_n),
    .load_i      (frameAccept),
    .advance_i   (dispatch),
    .re_origin_i (re_origin),
    .im_origin_i (im_origin),
    .step_i      (step),
    .x_o         (coordX),
    .y_o         (coordY),
    .re_o        (coordRe),
    .im_o        (coordIm),
    .last_o      (coordLast)
  );

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) stateQ <= IDLE;
    else          stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (frame_start) stateD = RUN;
      RUN:     if (dispatch && coordLast) stateD = DRAIN;
      DRAIN:   if (slotBusyQ == '0) stateD = DONE;
      DONE:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    busy       = (stateQ != IDLE);
    frame_done = (stateQ == DONE);
    runEn      = (stateQ == RUN);
  end

  // Dispatch only ever targets a free slot and retire only a valid one, so the updates never collide.
  always_comb begin
    issuePtrD  = issuePtrQ;
    retirePtrD = retirePtrQ;
    slotBusyD  = slotBusyQ;
    resValidD  = resValidQ | captureEn;
    if (frameAccept) begin
      issuePtrD  = '0;
      retirePtrD = '0;
    end
    if (dispatch) begin
      slotBusyD[issuePtrQ] = 1'b1;
      issuePtrD            = nextPtr(issuePtrQ);
    end
    if (retire) begin
      slotBusyD[retirePtrQ] = 1'b0;
      resValidD[retirePtrQ] = 1'b0;
      retirePtrD            = nextPtr(retirePtrQ);
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      issuePtrQ  <= '0;
      retirePtrQ <= '0;
      slotBusyQ  <= '0;
      resValidQ  <= '0;
      doneQ      <= '0;
      maxIterQ   <= '0;
    end else begin
      issuePtrQ  <= issuePtrD;
      retirePtrQ <= retirePtrD;
      slotBusyQ  <= slotBusyD;
      resValidQ  <= resValidD;
      doneQ      <= eng_done;
      if (frameAccept) maxIterQ <= max_iter_in;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        slotReQ[i]    <= '0;
        slotImQ[i]    <= '0;
        slotXQ[i]     <= '0;
        slotYQ[i]     <= '0;
        slotDepthQ[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) begin
        if (dispatch && (issuePtrQ == PTR_W'(i))) begin
          slotReQ[i] <= coordRe;
          slotImQ[i] <= coordIm;
          slotXQ[i]  <= coordX;
          slotYQ[i]  <= coordY;
        end
        if (captureEn[i]) slotDepthQ[i] <= eng_depth[i*DEPTH_W +: DEPTH_W];
      end
    end
  end

  // During the start cycle the engine sees the live coordinate; afterwards the slot copy holds it.
  always_comb begin
    eng_start = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      eng_re_c[i*COORD_W +: COORD_W] = slotReQ[i];
      eng_im_c[i*COORD_W +: COORD_W] = slotImQ[i];
      if (dispatch && (issuePtrQ == PTR_W'(i))) begin
        eng_start[i]                   = 1'b1;
        eng_re_c[i*COORD_W +: COORD_W] = coordRe;
        eng_im_c[i*COORD_W +: COORD_W] = coordIm;
      end
    end
  end

  assign eng_max_iter  = maxIterQ;
  assign pix.pix_valid = resValidQ[retirePtrQ];
  assign pix.pix_x     = slotXQ[retirePtrQ];
  assign pix.pix_y     = slotYQ[retirePtrQ];
  assign pix.pix_depth = slotDepthQ[retirePtrQ];
  assign pix.pix_sof   = resValidQ[retirePtrQ] && (slotXQ[retirePtrQ] == '0) && (slotYQ[retirePtrQ] == '0);
  assign pix.pix_eol   = resValidQ[retirePtrQ] && (slotXQ[retirePtrQ] == X_W'(H_RES - 1));

`ifdef SCHED_PERF_EN
  logic [31:0] perfCyclesQ, perfCyclesD, perfStallsQ, perfStallsD;

  always_comb begin
    perfCyclesD = perfCyclesQ;
    perfStallsD = perfStallsQ;
    if (frameAccept) begin
      perfCyclesD = '0;
      perfStallsD = '0;
    end else if ((stateQ == RUN) || (stateQ == DRAIN)) begin
      perfCyclesD = perfCyclesQ + 32'd1;
      if (pix.pix_valid && !pix.pix_ready) perfStallsD = perfStallsQ + 32'd1;
    end
  end

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      perfCyclesQ <= '0;
      perfStallsQ <= '0;
    end else begin
      perfCyclesQ <= perfCyclesD;
      perfStallsQ <= perfStallsD;
    end
  end

  assign perf_cycles = perfCyclesQ;
  assign perf_stalls = perfStallsQ;
`endif

endmodule

// File: tb/tb_mandel_pixel_scheduler.sv
// Directed bench: 4x2 raster on two modelled engines, checking coordinates, order, backpressure and reset.
module tb_mandel_pixel_scheduler;
  import mandel_sched_pkg::*;

  localparam int NE   = 2;
  localparam int HR   = 4;
  localparam int VR   = 2;
  localparam int NPIX = HR * VR;

  logic              sysclk      = 1'b0;
  logic              reset_n     = 1'b0;
  logic              frame_start = 1'b0;
  logic [15:0]       re_origin   = '0;
  logic [15:0]       im_origin   = '0;
  logic [15:0]       step        = '0;
  logic [7:0]        max_iter_in = '0;
  logic              busy, frame_done;
  logic [NE-1:0]     eng_start;
  logic [NE*16-1:0]  eng_re_c, eng_im_c;
  logic [7:0]        eng_max_iter;
  logic [NE-1:0]     eng_done  = '0;
  logic [NE*8-1:0]   eng_depth = '0;
`ifdef SCHED_PERF_EN
  logic [31:0]       perf_cycles, perf_stalls;
`endif

  mandel_pixel_scheduler_if pix ();

  mandel_pixel_scheduler #(
    .NUM_ENGINES (NE),
    .H_RES       (HR),
    .V_RES       (VR)
  ) dut (
    .sysclk       (sysclk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .re_origin    (re_origin),
    .im_origin    (im_origin),
    .step         (step),
    .max_iter_in  (max_iter_in),
    .busy         (busy),
    .frame_done   (frame_done),
    .eng_start    (eng_start),
    .eng_re_c     (eng_re_c),
    .eng_im_c     (eng_im_c),
    .eng_max_iter (eng_max_iter),
    .eng_done     (eng_done),
    .eng_depth    (eng_depth),
    .pix          (pix)
`ifdef SCHED_PERF_EN
    ,
    .perf_cycles  (perf_cycles),
    .perf_stalls  (perf_stalls)
`endif
  );

  always #5 sysclk = ~sysclk;

  int checkCount = 0;
  int failCount  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // View of the frame currently expected to be on screen.
  logic [15:0] expRe0 = '0, expIm0 = '0, expStep = '0;

  function automatic logic [15:0] expRe(input int k);
    return 16'(expRe0 + (k % HR) * expStep);
  endfunction

  function automatic logic [15:0] expIm(input int k);
    return 16'(expIm0 - (k / HR) * expStep);
  endfunction

  function automatic logic [7:0] depthOf(input logic [15:0] re, input logic [15:0] im);
    return re[7:0] ^ im[15:8] ^ {im[3:0], re[11:8]};
  endfunction

  // Engine models: fixed per-engine latency, done held until the next start.
  int          lat   [NE];
  int          cnt   [NE];
  logic [15:0] engRe [NE];
  logic [15:0] engIm [NE];

  always @(negedge sysclk) begin
    if (!reset_n) begin
      eng_done = '0;
      for (int i = 0; i < NE; i++) cnt[i] = 0;
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (eng_start[i]) begin
          eng_done[i] = 1'b0;
          cnt[i]      = lat[i];
          engRe[i]    = eng_re_c[i*16 +: 16];
          engIm[i]    = eng_im_c[i*16 +: 16];
        end else if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) begin
            eng_done[i]       = 1'b1;
            eng_depth[i*8 +: 8] = depthOf(engRe[i], engIm[i]);
          end
        end
      end
    end
  end

  // Monitor: every start and every accepted pixel is compared with the raster model.
  int pixIdx = 0, startIdx = 0, doneCount = 0;

  always @(negedge sysclk) begin
    if (!reset_n) begin
      pixIdx    = 0;
      startIdx  = 0;
      doneCount = 0;
    end else begin
      if (frame_start && !busy) begin
        pixIdx    = 0;
        startIdx  = 0;
        doneCount = 0;
      end
      for (int i = 0; i < NE; i++) begin
        if (eng_start[i]) begin
          checkOutput("startInFrame", 32'(startIdx < NPIX), 1);
          checkOutput("startEngine", i, startIdx % NE);
          checkOutput("startRe", eng_re_c[i*16 +: 16], expRe(startIdx));
          checkOutput("startIm", eng_im_c[i*16 +: 16], expIm(startIdx));
          startIdx++;
        end
      end
      if (pix.pix_valid && pix.pix_ready) begin
        checkOutput("pixX", pix.pix_x, pixIdx % HR);
        checkOutput("pixY", pix.pix_y, pixIdx / HR);
        checkOutput("pixDepth", pix.pix_depth, depthOf(expRe(pixIdx), expIm(pixIdx)));
        checkOutput("pixSof", pix.pix_sof, 32'(pixIdx == 0));
        checkOutput("pixEol", pix.pix_eol, 32'((pixIdx % HR) == HR - 1));
        pixIdx++;
      end
      if (frame_done) doneCount++;
    end
  end

  task automatic applyStimulus(input logic [15:0] r, input logic [15:0] i,
                               input logic [15:0] s, input logic [7:0] m);
    @(posedge sysclk); #1;
    re_origin   = r;
    im_origin   = i;
    step        = s;
    max_iter_in = m;
    expRe0      = r;
    expIm0      = i;
    expStep     = s;
    frame_start = 1'b1;
    @(posedge sysclk); #1;
    frame_start = 1'b0;
    @(negedge sysclk);
    checkOutput("busyAfterStart", busy, 1);
    checkOutput("firstStartEng0", eng_start, 1);
  endtask

  task automatic waitFrameDone(input string tag);
    int n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (frame_done !== 1'b1 && n < 400);
    checkOutput({tag, "DoneInTime"}, 32'(n < 400), 1);
    checkOutput({tag, "BusyAtDone"}, busy, 1);
    checkOutput({tag, "PixCount"}, pixIdx, NPIX);
    checkOutput({tag, "StartCount"}, startIdx, NPIX);
    @(negedge sysclk);
    checkOutput({tag, "DonePulse"}, frame_done, 0);
    checkOutput({tag, "BusyDrops"}, busy, 0);
    checkOutput({tag, "DoneCount"}, doneCount, 1);
  endtask

  initial begin
    int n;
    logic [31:0] heldX, heldY, heldD;
    int extraStarts;

    pix.pix_ready = 1'b1;
    lat[0] = 5;
    lat[1] = 5;
    repeat (3) @(posedge sysclk);
    #1;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstFrameDone", frame_done, 0);
    checkOutput("rstEngStart", eng_start, 0);
    checkOutput("rstEngRe", eng_re_c, 0);
    checkOutput("rstPixValid", pix.pix_valid, 0);
    checkOutput("rstPixSof", pix.pix_sof, 0);
    checkOutput("rstMaxIter", eng_max_iter, 0);
    @(posedge sysclk); #1;
    reset_n = 1'b1;

    // Frame A: fixed latency, pixel (3,1) must be driven as 0xFEC0 / 0x00C0.
    applyStimulus(16'hFE00, 16'h0100, 16'h0040, 8'h20);
    checkOutput("maxIterA", eng_max_iter, 8'h20);
    checkOutput("pixel31Re", expRe(7), 16'hFEC0);
    checkOutput("pixel31Im", expIm(7), 16'h00C0);
    waitFrameDone("frameA");

    // Frame B: engine1 faster than engine0, plus a frame_start pulse while busy.
    lat[0] = 7;
    lat[1] = 2;
    applyStimulus(16'h0000, 16'h0000, 16'h0101, 8'h40);
    repeat (3) @(posedge sysclk);
    #1;
    re_origin   = 16'h1234;
    im_origin   = 16'h4321;
    step        = 16'h7777;
    max_iter_in = 8'hFF;
    frame_start = 1'b1;
    @(posedge sysclk); #1;
    frame_start = 1'b0;
    waitFrameDone("frameB");
    checkOutput("maxIterB", eng_max_iter, 8'h40);

    // Frame C: 20 cycles of backpressure once a pixel is waiting.
    lat[0] = 5;
    lat[1] = 5;
    applyStimulus(16'h0400, 16'hFC00, 16'hFFC0, 8'h10);
    n = 0;
    while (pixIdx < 3 && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    checkOutput("reachMidFrame", 32'(n < 200), 1);
    @(posedge sysclk); #1;
    pix.pix_ready = 1'b0;
    n = 0;
    do begin
      @(negedge sysclk);
      n++;
    end while (!pix.pix_valid && n < 50);
    checkOutput("validUnderStall", pix.pix_valid, 1);
    heldX = 32'(pix.pix_x);
    heldY = 32'(pix.pix_y);
    heldD = 32'(pix.pix_depth);
    extraStarts = 0;
    repeat (19) begin
      @(negedge sysclk);
      checkOutput("stallValid", pix.pix_valid, 1);
      checkOutput("stallX", pix.pix_x, heldX);
      checkOutput("stallY", pix.pix_y, heldY);
      checkOutput("stallDepth", pix.pix_depth, heldD);
      if (eng_start != '0) extraStarts++;
    end
    checkOutput("stallStarts", extraStarts, 0);
    @(posedge sysclk); #1;
    pix.pix_ready = 1'b1;
    waitFrameDone("frameC");
`ifdef SCHED_PERF_EN
    checkOutput("perfStalls", perf_stalls, 20);
    checkOutput("perfCyclesAboveStalls", 32'(perf_cycles > 32'd20), 1);
`endif

    // Frame D aborted by reset, then frame E must run cleanly.
    applyStimulus(16'h2000, 16'hE000, 16'h0010, 8'h08);
    repeat (6) @(posedge sysclk);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortEngStart", eng_start, 0);
    checkOutput("abortEngRe", eng_re_c, 0);
    checkOutput("abortEngIm", eng_im_c, 0);
    checkOutput("abortPixValid", pix.pix_valid, 0);
    checkOutput("abortMaxIter", eng_max_iter, 0);
    repeat (2) @(posedge sysclk);
    #1;
    reset_n = 1'b1;
    applyStimulus(16'h8000, 16'h7FF0, 16'h1234, 8'h99);
    waitFrameDone("frameE");

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks %0d", checkCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mandel_pixel_scheduler.md
# mandel_pixel_scheduler

Frame-level scheduler that sweeps the screen raster, computes each pixel's complex coordinate c from a latched view (origin, step), and farms pixels out round-robin to NUM_ENGINES escape-time depth engines. Results are retired in raster order onto a valid/ready pixel stream toward the colour-mapping/framebuffer stage. It sits between the PYNQ-side configuration registers and the engine array.

## Interface
- FRAC, 8: fractional bits of all Q-format coordinates (16-bit signed).
- NUM_ENGINES, 4: number of depth engines driven, ≥2.
- H_RES, 640: pixels per line; V_RES, 480: lines per frame.
- sysclk  in  1  single clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  pulse; latches view and begins a frame when idle.
- re_origin, im_origin  in  16  signed c of pixel (0,0) (top-left).
- step  in  16  signed per-pixel increment.
- max_iter_in  in  8  iteration limit for the frame.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after last pixel retired.
- eng_start  out  NUM_ENGINES  per-engine start pulse.
- eng_re_c, eng_im_c  out  NUM_ENGINES*16  per-engine c, held from start until result captured.
- eng_max_iter  out  8  latched limit, shared.
- eng_done  in  NUM_ENGINES  per-engine level done.
- eng_depth  in  NUM_ENGINES*8  per-engine final depth.
- pix_valid  out  1; pix_ready  in  1  output handshake.
- pix_x  out  10; pix_y  out  9; pix_depth  out  8.
- pix_sof  out  1  first pixel of frame; pix_eol  out  1  last pixel of a line.

## Operation
- States: IDLE, RUN, DRAIN, DONE. IDLE→RUN on frame_start; RUN→DRAIN when last pixel issued; DRAIN→DONE when all engines free and no result pending; DONE→IDLE next cycle (frame_done=1 in DONE).
- frame_start while busy is ignored. Latched: origins, step, max_iter.
- Coordinate generator: re = re_origin + x·step, im = im_origin − y·step, computed incrementally (add per pixel; re reloads at line wrap, im −= step). 16-bit two's-complement wrap, no saturation.
- Dispatch: issue_ptr round-robin. Per cycle, if RUN, engine[issue_ptr] free: pulse eng_start, load its eng_re_c/eng_im_c and x/y tag, mark busy, advance raster and issue_ptr. At most one dispatch/cycle; else wait (no skipping).
- Capture: rising edge of eng_done (done & ~done_q) on a busy engine stores eng_depth into that slot's result register, sets res_valid. Done level ignored otherwise (stale done after start is filtered).
- Retire: retire_ptr round-robin follows issue order, so output is raster order. pix_valid = res_valid[retire_ptr]; on valid&ready, free slot, advance retire_ptr. Freed slot dispatchable next cycle.
- Capture and retire of different slots in the same cycle both take effect.
- pix_x/y/depth/sof/eol stable while pix_valid & !pix_ready.

## Timing
- Reset values: every output 0, state IDLE, pointers 0, all slots free.
- frame_start at cycle N → busy and first eng_start at N+1 (pixel 0,0); pixel k≥1 issued no earlier than N+1+k.
- Result presented the cycle after the done edge is sampled.
- frame_done exactly one cycle; busy drops the cycle after.
- Reset mid-frame: immediate abort, all state as reset; engines must be reset together.

## Configuration
- SCHED_PERF_EN: when defined, adds outputs perf_cycles[31:0] (cycles busy in last frame) and perf_stalls[31:0] (cycles pix_valid & !pix_ready), both cleared on frame_start, frozen at frame_done. Undefined: ports and counters absent; functionality otherwise identical.

## Structure
- Package mandel_sched_pkg: state enum, COORD_W=16, DEPTH_W=8, X_W=10, Y_W=9, default H_RES/V_RES.
- Sub-module mandel_coord_gen: raster x/y counters, wrap, incremental re/im accumulators, last-pixel flag.

## Test plan
- H_RES=4, V_RES=2, NUM_ENGINES=2, engine models fixed latency 5: 8 pixels emerge in raster order, pix_sof on (0,0), pix_eol on x=3, one frame_done.
- Engine models with varying latency (engine1 faster than engine0): output still raster order; engine1 result waits until engine0 retires.
- origin=(−2.0,1.0) → 0xFE00/0x0100, step=0x0040: pixel (3,1) drives re_c 0xFEC0, im_c 0x00C0.
- pix_ready held low 20 cycles mid-frame: outputs stable, no dispatch beyond free slots, no pixel lost/duplicated.
- frame_start pulsed again while busy: ignored, view unchanged; reset_n low mid-frame: all outputs 0 next edge, new frame afterwards correct.
- With SCHED_PERF_EN, backpressure 20 cycles: perf_stalls=20 after frame_done.
